phase_frame_ctrl: RTL and testbench

Configuration controller between the UART receiver and the phased-array waveform generator. It parses framed phase-delay commands from the received byte stream and validates each frame's checksum. On a good frame it commits all channel phases to the generator at once, so outputs never show a half-updated set. It returns a one-byte ACK or NAK to the UART transmitter and keeps frame and error statistics.

---
 rtl/phase_cfg_pkg.sv | 29 ++
 rtl/phase_frame_ctrl_if.sv | 60 ++++++
 rtl/phase_frame_ctrl_edge_strobe.sv | 32 +++
 rtl/phase_frame_ctrl.sv | 165 ++++++++++++++++
 tb/tb_phase_frame_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phase_cfg_pkg.sv
// ---------------------------------------------------------------------------------------------
// phase_cfg_pkg
//   Shared definitions for the phased-array configuration path:
//   - FSM state encoding of the frame controller
//   - default header / response byte values and channel count
//   - saturating 8-bit increment used by the statistics counters
// ---------------------------------------------------------------------------------------------
package phase_cfg_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPayload,
      StCheck,
      StCommit,
      StAck
   } state_e;

   localparam int unsigned NCH_DEF     = 8;
   localparam int unsigned TIMEOUT_DEF = 50000;
   localparam logic [7:0]  HDR_DEF     = 8'hAA;
   localparam logic [7:0]  ACK_DEF     = 8'h55;
   localparam logic [7:0]  NAK_DEF     = 8'hEE;

   // Statistics counters stick at all-ones instead of wrapping.
   function automatic logic [7:0] sat_inc(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/phase_frame_ctrl_if.sv
// ---------------------------------------------------------------------------------------------
// phase_frame_ctrl_if
//   Bundles the UART-side handshake and the generator-side configuration outputs of the
//   phase frame controller.
//   master : controller view (receives rx/tx status, drives response and config outputs)
//   slave  : environment view (drives rx byte stream and tx_busy, observes outputs)
//   Signals:
//     rx_data    8      received byte, valid on the strobe cycle
//     rx_int     1      uart_rx busy level; falling edge marks a new byte
//     tx_busy    1      transmitter busy
//     tx_req     1      one-cycle request to send tx_byte
//     tx_byte    8      response byte (ACK/NAK)
//     phase_bus  8*NCH  committed channel phases, channel k at [8k+7:8k]
//     cfg_update 1      one-cycle pulse aligned with a new phase_bus
//     frame_cnt  8      committed frames, saturating
//     err_cnt    8      checksum failures plus timeouts, saturating
//     overrun    1      sticky: byte dropped while waiting to respond
// ---------------------------------------------------------------------------------------------
interface phase_frame_ctrl_if #(
   parameter int unsigned NCH = 8
);

   logic [7:0]       rx_data;
   logic             rx_int;
   logic             tx_busy;
   logic             tx_req;
   logic [7:0]       tx_byte;
   logic [8*NCH-1:0] phase_bus;
   logic             cfg_update;
   logic [7:0]       frame_cnt;
   logic [7:0]       err_cnt;
   logic             overrun;

   modport master (
      input  rx_data,
      input  rx_int,
      input  tx_busy,
      output tx_req,
      output tx_byte,
      output phase_bus,
      output cfg_update,
      output frame_cnt,
      output err_cnt,
      output overrun
   );

   modport slave (
      output rx_data,
      output rx_int,
      output tx_busy,
      input  tx_req,
      input  tx_byte,
      input  phase_bus,
      input  cfg_update,
      input  frame_cnt,
      input  err_cnt,
      input  overrun
   );

endinterface

// File: rtl/phase_frame_ctrl_edge_strobe.sv
// ---------------------------------------------------------------------------------------------
// edge_strobe
//   Turns a UART receiver busy level into a one-cycle byte strobe. The level is registered
//   once and the strobe fires on the cycle the live level is low while the registered copy is
//   still high, so the consumer samples the byte in the same cycle.
//   Ports:
//     clk_i    system clock
//     rst_i    synchronous reset, active-high
//     level_i  receiver busy level
//     stb_o    one-cycle strobe on a 1->0 transition of level_i
// ---------------------------------------------------------------------------------------------
module edge_strobe (
   input  logic clk_i,
   input  logic rst_i,
   input  logic level_i,
   output logic stb_o
);

   logic level_q;

   // Reset to low so a receiver already idle-low never produces a spurious strobe.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_i;
      end
   end

   assign stb_o = level_q & ~level_i;

endmodule

// File: rtl/phase_frame_ctrl.sv
// ---------------------------------------------------------------------------------------------
// phase_frame_ctrl
//   Parses frames of the form HDR, NCH phase bytes, XOR checksum from the UART byte stream.
//   A good frame commits all phases to phase_bus in one cycle (with a cfg_update pulse) and
//   answers ACK; a bad checksum answers NAK; an inter-byte gap of TIMEOUT_CYC cycles inside a
//   frame aborts it silently. Frame and error counts saturate at 255.
//   Ports:
//     sys_clk   system clock
//     sys_rstn  synchronous reset, active-high (clears every output and the partial frame)
//     bus       phase_frame_ctrl_if.master: rx byte stream, tx response, config outputs
// ---------------------------------------------------------------------------------------------
module phase_frame_ctrl
   import phase_cfg_pkg::*;
#(
   parameter int unsigned NCH         = NCH_DEF,
   parameter logic [7:0]  HDR_BYTE    = HDR_DEF,
   parameter logic [7:0]  ACK_BYTE    = ACK_DEF,
   parameter logic [7:0]  NAK_BYTE    = NAK_DEF,
   parameter int unsigned TIMEOUT_CYC = TIMEOUT_DEF
) (
   input  logic                sys_clk,
   input  logic                sys_rstn,
   phase_frame_ctrl_if.master  bus
);

   localparam int unsigned IdxW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned GapW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   localparam logic [IdxW-1:0] IdxLast = IdxW'(NCH - 1);
   localparam logic [GapW-1:0] GapMax  = GapW'(TIMEOUT_CYC - 1);

   state_e           state_q;
   logic [IdxW-1:0]  idx_q;
   logic [7:0]       xor_q;
   logic [GapW-1:0]  gap_q;
   logic [7:0]       shadow_q [NCH];
   logic [8*NCH-1:0] phase_q;
   logic             cfg_update_q;
   logic             tx_req_q;
   logic [7:0]       tx_byte_q;
   logic [7:0]       frame_cnt_q;
   logic [7:0]       err_cnt_q;
   logic             overrun_q;

   logic             byte_stb;

   edge_strobe u_edge_strobe (
      .clk_i   (sys_clk),
      .rst_i   (sys_rstn),
      .level_i (bus.rx_int),
      .stb_o   (byte_stb)
   );

   // Single-process FSM; every output is a register so the generator never sees glitches.
   always_ff @(posedge sys_clk) begin
      if (sys_rstn) begin
         state_q      <= StIdle;
         idx_q        <= '0;
         xor_q        <= '0;
         gap_q        <= '0;
         phase_q      <= '0;
         cfg_update_q <= 1'b0;
         tx_req_q     <= 1'b0;
         tx_byte_q    <= '0;
         frame_cnt_q  <= '0;
         err_cnt_q    <= '0;
         overrun_q    <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            shadow_q[k] <= '0;
         end
      end else begin
         cfg_update_q <= 1'b0;
         tx_req_q     <= 1'b0;

         unique case (state_q)
            StIdle: begin
               gap_q <= '0;
               // Non-header bytes between frames are line noise, not errors.
               if (byte_stb && (bus.rx_data == HDR_BYTE)) begin
                  idx_q   <= '0;
                  xor_q   <= '0;
                  state_q <= StPayload;
               end
            end

            StPayload: begin
               // A byte landing on the timeout cycle still counts: strobe is tested first.
               if (byte_stb) begin
                  gap_q           <= '0;
                  shadow_q[idx_q] <= bus.rx_data;
                  xor_q           <= xor_q ^ bus.rx_data;
                  idx_q           <= idx_q + IdxW'(1);
                  if (idx_q == IdxLast) begin
                     state_q <= StCheck;
                  end
               end else if (gap_q == GapMax) begin
                  gap_q     <= '0;
                  err_cnt_q <= sat_inc(err_cnt_q);
                  state_q   <= StIdle;
               end else begin
                  gap_q <= gap_q + GapW'(1);
               end
            end

            StCheck: begin
               if (byte_stb) begin
                  gap_q <= '0;
                  if (bus.rx_data == xor_q) begin
                     // Outputs are registered on entry so the COMMIT cycle itself shows the
                     // new phases together with cfg_update.
                     for (int k = 0; k < NCH; k++) begin
                        phase_q[8*k +: 8] <= shadow_q[k];
                     end
                     cfg_update_q <= 1'b1;
                     frame_cnt_q  <= sat_inc(frame_cnt_q);
                     tx_byte_q    <= ACK_BYTE;
                     state_q      <= StCommit;
                  end else begin
                     err_cnt_q <= sat_inc(err_cnt_q);
                     tx_byte_q <= NAK_BYTE;
                     state_q   <= StAck;
                  end
               end else if (gap_q == GapMax) begin
                  gap_q     <= '0;
                  err_cnt_q <= sat_inc(err_cnt_q);
                  state_q   <= StIdle;
               end else begin
                  gap_q <= gap_q + GapW'(1);
               end
            end

            StCommit: begin
               gap_q   <= '0;
               state_q <= StAck;
            end

            StAck: begin
               gap_q <= '0;
               // Nothing is buffered while the response is pending; flag the loss.
               if (byte_stb) begin
                  overrun_q <= 1'b1;
               end
               if (!bus.tx_busy) begin
                  tx_req_q <= 1'b1;
                  state_q  <= StIdle;
               end
            end

            default: begin
               gap_q   <= '0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.phase_bus  = phase_q;
   assign bus.cfg_update = cfg_update_q;
   assign bus.tx_req     = tx_req_q;
   assign bus.tx_byte    = tx_byte_q;
   assign bus.frame_cnt  = frame_cnt_q;
   assign bus.err_cnt    = err_cnt_q;
   assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_phase_frame_ctrl.sv
// ---------------------------------------------------------------------------------------------
// tb_phase_frame_ctrl
//   Directed bench for phase_frame_ctrl with hand-computed expectations.
// ---------------------------------------------------------------------------------------------
module tb_phase_frame_ctrl;

   localparam int unsigned TO = 64;

   logic clk;
   logic rst;

   int n_checks;
   int n_fail;
   int cfg_pulses;
   int req_pulses;

   phase_frame_ctrl_if #(.NCH(8)) bus ();

   phase_frame_ctrl #(
      .NCH         (8),
      .HDR_BYTE    (8'hAA),
      .ACK_BYTE    (8'h55),
      .NAK_BYTE    (8'hEE),
      .TIMEOUT_CYC (TO)
   ) dut (
      .sys_clk  (clk),
      .sys_rstn (rst),
      .bus      (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.cfg_update === 1'b1) cfg_pulses <= cfg_pulses + 1;
      if (bus.tx_req === 1'b1)     req_pulses <= req_pulses + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns one cycle after the strobe was consumed (cycle N+1 for that byte).
   task automatic send_byte(input logic [7:0] b);
      bus.rx_data = b;
      bus.rx_int  = 1'b1;
      tick(2);
      bus.rx_int  = 1'b0;
      tick(1);
   endtask

   task automatic send_frame(input logic [63:0] payload, input logic [7:0] chk);
      send_byte(8'hAA);
      for (int k = 0; k < 8; k++) send_byte(payload[8*k +: 8]);
      send_byte(chk);
   endtask

   task automatic do_reset();
      bus.rx_int  = 1'b0;
      bus.rx_data = 8'h00;
      bus.tx_busy = 1'b0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if (bus.phase_bus !== 64'h0) begin
         n_fail++; $display("FAIL reset.phase_bus got %h want 0", bus.phase_bus);
      end
      n_checks++;
      if ({bus.tx_req, bus.cfg_update, bus.overrun} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset.flags got %b want 000", {bus.tx_req, bus.cfg_update, bus.overrun});
      end
      n_checks++;
      if ({bus.tx_byte, bus.frame_cnt, bus.err_cnt} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset.bytes got %h want 000000", {bus.tx_byte, bus.frame_cnt, bus.err_cnt});
      end
   endtask

   task automatic test_good_frame();
      int c0, r0;
      do_reset();
      c0 = cfg_pulses; r0 = req_pulses;
      send_frame(64'h0807060504030201, 8'h08);
      n_checks++;
      if (bus.phase_bus !== 64'h0807060504030201) begin
         n_fail++; $display("FAIL good.phase_bus got %h want 0807060504030201", bus.phase_bus);
      end
      n_checks++;
      if (bus.cfg_update !== 1'b1) begin
         n_fail++; $display("FAIL good.cfg_update got %b want 1", bus.cfg_update);
      end
      n_checks++;
      if (bus.frame_cnt !== 8'd1) begin
         n_fail++; $display("FAIL good.frame_cnt got %0d want 1", bus.frame_cnt);
      end
      n_checks++;
      if (bus.tx_req !== 1'b0) begin
         n_fail++; $display("FAIL good.tx_req_early got %b want 0", bus.tx_req);
      end
      tick(1);
      n_checks++;
      if ({bus.cfg_update, bus.tx_req} !== 2'b00) begin
         n_fail++; $display("FAIL good.n2 got %b want 00", {bus.cfg_update, bus.tx_req});
      end
      tick(1);
      n_checks++;
      if ({bus.tx_req, bus.tx_byte} !== {1'b1, 8'h55}) begin
         n_fail++; $display("FAIL good.ack got %b/%h want 1/55", bus.tx_req, bus.tx_byte);
      end
      tick(1);
      n_checks++;
      if ((cfg_pulses - c0) !== 1 || (req_pulses - r0) !== 1 || bus.tx_req !== 1'b0) begin
         n_fail++;
         $display("FAIL good.pulses got cfg=%0d req=%0d tx_req=%b want 1 1 0",
                  cfg_pulses - c0, req_pulses - r0, bus.tx_req);
      end
   endtask

   task automatic test_bad_checksum();
      int c0, r0;
      do_reset();
      c0 = cfg_pulses; r0 = req_pulses;
      send_frame(64'h0807060504030201, 8'h00);
      n_checks++;
      if ({bus.err_cnt, bus.tx_byte} !== {8'd1, 8'hEE}) begin
         n_fail++; $display("FAIL bad.err_nak got %0d/%h want 1/ee", bus.err_cnt, bus.tx_byte);
      end
      tick(1);
      n_checks++;
      if (bus.tx_req !== 1'b1) begin
         n_fail++; $display("FAIL bad.tx_req got %b want 1", bus.tx_req);
      end
      tick(2);
      n_checks++;
      if (bus.phase_bus !== 64'h0 || bus.frame_cnt !== 8'd0) begin
         n_fail++;
         $display("FAIL bad.no_commit got %h/%0d want 0/0", bus.phase_bus, bus.frame_cnt);
      end
      n_checks++;
      if ((cfg_pulses - c0) !== 0 || (req_pulses - r0) !== 1) begin
         n_fail++;
         $display("FAIL bad.pulses got cfg=%0d req=%0d want 0 1", cfg_pulses - c0, req_pulses - r0);
      end
   endtask

   task automatic test_timeout();
      int r0;
      do_reset();
      r0 = req_pulses;
      send_byte(8'hAA);
      send_byte(8'h10);
      send_byte(8'h20);
      tick(TO - 2);
      n_checks++;
      if (bus.err_cnt !== 8'd0) begin
         n_fail++; $display("FAIL timeout.early got %0d want 0", bus.err_cnt);
      end
      tick(2);
      n_checks++;
      if (bus.err_cnt !== 8'd1) begin
         n_fail++; $display("FAIL timeout.err_cnt got %0d want 1", bus.err_cnt);
      end
      tick(5);
      n_checks++;
      if ((req_pulses - r0) !== 0 || bus.phase_bus !== 64'h0) begin
         n_fail++;
         $display("FAIL timeout.silent got req=%0d phase=%h want 0 0", req_pulses - r0,
                  bus.phase_bus);
      end
      send_frame(64'h0807060504030201, 8'h08);
      n_checks++;
      if (bus.phase_bus !== 64'h0807060504030201 || bus.frame_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL timeout.recover got %h/%0d want 0807060504030201/1", bus.phase_bus,
                  bus.frame_cnt);
      end
      tick(3);
   endtask

   task automatic test_noise_header();
      int r0;
      do_reset();
      r0 = req_pulses;
      send_byte(8'h00);
      send_byte(8'hFF);
      n_checks++;
      if (bus.err_cnt !== 8'd0 || (req_pulses - r0) !== 0) begin
         n_fail++;
         $display("FAIL noise.ignored got err=%0d req=%0d want 0 0", bus.err_cnt, req_pulses - r0);
      end
      // 01^02^03^AA^05^06^07^08 = A6
      send_frame(64'h08070605AA030201, 8'hA6);
      n_checks++;
      if (bus.phase_bus !== 64'h08070605AA030201 || bus.frame_cnt !== 8'd1) begin
         n_fail++;
         $display("FAIL noise.embedded_hdr got %h/%0d want 08070605aa030201/1", bus.phase_bus,
                  bus.frame_cnt);
      end
      tick(3);
   endtask

   task automatic test_backpressure();
      int r0, c0;
      do_reset();
      bus.tx_busy = 1'b1;
      r0 = req_pulses; c0 = cfg_pulses;
      send_frame(64'h0807060504030201, 8'h08);
      tick(1);
      send_byte(8'hAA);
      n_checks++;
      if (bus.overrun !== 1'b1) begin
         n_fail++; $display("FAIL bp.overrun got %b want 1", bus.overrun);
      end
      tick(990);
      n_checks++;
      if (bus.tx_req !== 1'b0 || (req_pulses - r0) !== 0 || bus.tx_byte !== 8'h55) begin
         n_fail++;
         $display("FAIL bp.held got req=%b cnt=%0d byte=%h want 0 0 55", bus.tx_req,
                  req_pulses - r0, bus.tx_byte);
      end
      bus.tx_busy = 1'b0;
      tick(1);
      n_checks++;
      if (bus.tx_req !== 1'b1) begin
         n_fail++; $display("FAIL bp.release got %b want 1", bus.tx_req);
      end
      tick(1);
      // Payload without header: only valid as a frame if the dropped AA had started one.
      for (int k = 1; k <= 8; k++) send_byte(8'(k));
      send_byte(8'h08);
      tick(3);
      n_checks++;
      if (bus.frame_cnt !== 8'd1 || (cfg_pulses - c0) !== 1 || bus.overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL bp.no_frame got frames=%0d cfg=%0d ovr=%b want 1 1 1", bus.frame_cnt,
                  cfg_pulses - c0, bus.overrun);
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      bus.tx_busy = 1'b1;
      send_frame(64'h0807060504030201, 8'h08);
      tick(1);
      send_byte(8'h77);
      bus.tx_busy = 1'b0;
      tick(3);
      send_byte(8'hAA);
      send_byte(8'h01);
      send_byte(8'h02);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      n_checks++;
      if (bus.phase_bus !== 64'h0 || {bus.tx_byte, bus.frame_cnt, bus.err_cnt} !== 24'h0 ||
          {bus.overrun, bus.tx_req, bus.cfg_update} !== 3'b000) begin
         n_fail++;
         $display("FAIL midrst.outputs got %h %h %0d %0d %b want all zero", bus.phase_bus,
                  bus.tx_byte, bus.frame_cnt, bus.err_cnt, bus.overrun);
      end
      send_frame(64'h1111111111111111, 8'h00);
      n_checks++;
      if (bus.phase_bus !== 64'h1111111111111111 || bus.frame_cnt !== 8'd1 ||
          bus.cfg_update !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst.commit got %h/%0d/%b want 1111111111111111/1/1", bus.phase_bus,
                  bus.frame_cnt, bus.cfg_update);
      end
      tick(3);
   endtask

   task automatic test_back_to_back();
      int c0;
      do_reset();
      c0 = cfg_pulses;
      send_frame(64'h0807060504030201, 8'h08);
      tick(2);
      send_frame(64'h2222222222222222, 8'h00);
      n_checks++;
      if (bus.phase_bus !== 64'h2222222222222222 || bus.frame_cnt !== 8'd2) begin
         n_fail++;
         $display("FAIL b2b.second got %h/%0d want 2222222222222222/2", bus.phase_bus,
                  bus.frame_cnt);
      end
      tick(3);
      n_checks++;
      if ((cfg_pulses - c0) !== 2) begin
         n_fail++; $display("FAIL b2b.cfg_pulses got %0d want 2", cfg_pulses - c0);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 256; i++) begin
         send_frame(64'h0807060504030201, 8'h08);
         tick(2);
      end
      n_checks++;
      if (bus.frame_cnt !== 8'hFF) begin
         n_fail++; $display("FAIL sat.frame_cnt got %0d want 255", bus.frame_cnt);
      end
      for (int i = 0; i < 256; i++) begin
         send_frame(64'h0807060504030201, 8'h00);
         tick(2);
      end
      n_checks++;
      if (bus.err_cnt !== 8'hFF || bus.frame_cnt !== 8'hFF) begin
         n_fail++;
         $display("FAIL sat.err_cnt got %0d/%0d want 255/255", bus.err_cnt, bus.frame_cnt);
      end
   endtask

   initial begin
      n_checks    = 0;
      n_fail      = 0;
      rst         = 1'b1;
      bus.rx_int  = 1'b0;
      bus.rx_data = 8'h00;
      bus.tx_busy = 1'b0;
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_timeout();
      test_noise_header();
      test_backpressure();
      test_reset_mid_frame();
      test_back_to_back();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
